// File: rtl/csa_accum_ctrl_if.sv
// Operand/result handshake bundle for the carry-save accumulator controller.
interface csa_accum_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [7:0]       out_count;
    logic             busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, busy
    );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: carry-save compression on input, then a shared
// 4-bit ripple slice resolves S+C one nibble per cycle.
module ripple_carry_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[4];
endmodule

module csa_accum_ctrl #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst,
    csa_accum_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

    state_t           state, state_nxt;
    logic             out_vld;
    logic [WIDTH-1:0] s_vec, c_vec, result;
    logic [KW-1:0]    k;
    logic             carry;
    logic [7:0]       count;
    logic             accept, take, last_nib;
    logic [3:0]       nib_sum;
    logic             nib_cout;

    assign accept   = bus.in_valid & bus.in_ready;
    assign take     = out_vld & bus.out_ready;
    assign last_nib = (k == KW'(NIB - 1));

    ripple_carry_4_bit u_slice (
        .a   (s_vec[{k, 2'b00} +: 4]),
        .b   (c_vec[{k, 2'b00} +: 4]),
        .cin (carry),
        .sum (nib_sum),
        .cout(nib_cout)
    );

    // out_valid is registered, so DONE spends one cycle presenting before
    // the result is offered; a handshake can only happen once it is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCUM;
            out_vld <= 1'b0;
        end else begin
            state   <= state_nxt;
            out_vld <= (state == DONE) & ~take;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && bus.in_last) state_nxt = RESOLVE;
            RESOLVE: if (last_nib)              state_nxt = DONE;
            DONE:    if (take)                  state_nxt = ACCUM;
            default:                            state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ACCUM) & ~rst;
        bus.out_valid = out_vld;
        bus.out_sum   = out_vld ? result : '0;
        bus.out_count = out_vld ? count : 8'd0;
        bus.busy      = (state != ACCUM) | (count != 8'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_vec  <= '0;
            c_vec  <= '0;
            result <= '0;
            k      <= '0;
            carry  <= 1'b0;
            count  <= 8'd0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        s_vec <= s_vec ^ c_vec ^ bus.in_data;
                        c_vec <= ((s_vec & c_vec) | (s_vec & bus.in_data) |
                                  (c_vec & bus.in_data)) << 1;
                        count <= (count == 8'hFF) ? count : count + 8'd1;
                        if (bus.in_last) begin
                            k     <= '0;
                            carry <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    result[{k, 2'b00} +: 4] <= nib_sum;
                    carry                   <= nib_cout;
                    k                       <= k + 1'b1;
                end
                DONE: begin
                    if (take) begin
                        s_vec <= '0;
                        c_vec <= '0;
                        count <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl (WIDTH=16): sums, latency, backpressure,
// mid-resolve reset and count saturation.
module tb_csa_accum_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   lat;

    always #5 clk = ~clk;

    csa_accum_ctrl_if #(.WIDTH(16)) ifc ();

    csa_accum_ctrl #(.WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_last  = l;
        while (!ifc.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, ifc.in_ready}, 32'd1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    // Counts negedges from the one after the last accept until out_valid.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!ifc.out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("out_valid_seen", {31'd0, ifc.out_valid}, 32'd1);
    endtask

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_in_ready",  {31'd0, ifc.in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, ifc.busy},      32'd0);
        chk("rst_out_sum",   {16'd0, ifc.out_sum},   32'd0);
        chk("rst_out_count", {24'd0, ifc.out_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        @(negedge clk);

        // 1: three operands back-to-back, out_ready held high
        send(16'h1234, 1'b0);
        chk("t1_busy", {31'd0, ifc.busy}, 32'd1);
        send(16'h1111, 1'b0);
        send(16'h0001, 1'b1);
        chk("t1_in_ready_resolve", {31'd0, ifc.in_ready}, 32'd0);
        wait_out(lat);
        chk("t1_latency", lat, 32'd5);
        chk("t1_sum",   {16'd0, ifc.out_sum},   32'h2346);
        chk("t1_count", {24'd0, ifc.out_count}, 32'd3);
        @(negedge clk);
        chk("t1_valid_drop", {31'd0, ifc.out_valid}, 32'd0);
        chk("t1_in_ready",   {31'd0, ifc.in_ready},  32'd1);

        // 2: full carry ripple
        send(16'hFFFF, 1'b0);
        send(16'h0001, 1'b1);
        wait_out(lat);
        chk("t2_latency", lat, 32'd5);
        chk("t2_sum",   {16'd0, ifc.out_sum},   32'h0000);
        chk("t2_count", {24'd0, ifc.out_count}, 32'd2);
        @(negedge clk);

        // 3: single-operand set
        send(16'hABCD, 1'b1);
        wait_out(lat);
        chk("t3_latency", lat, 32'd5);
        chk("t3_sum",   {16'd0, ifc.out_sum},   32'hABCD);
        chk("t3_count", {24'd0, ifc.out_count}, 32'd1);
        @(negedge clk);

        // 4: backpressure in DONE with in_valid driven
        ifc.out_ready = 1'b0;
        send(16'h0010, 1'b0);
        send(16'h0020, 1'b1);
        wait_out(lat);
        ifc.in_valid = 1'b1;
        ifc.in_data  = 16'h7777;
        ifc.in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'd0, ifc.out_valid}, 32'd1);
            chk("t4_hold_sum",   {16'd0, ifc.out_sum},   32'h0030);
            chk("t4_hold_count", {24'd0, ifc.out_count}, 32'd2);
            chk("t4_hold_ready", {31'd0, ifc.in_ready},  32'd0);
        end
        ifc.in_valid  = 1'b0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        chk("t4_in_ready",  {31'd0, ifc.in_ready},  32'd1);
        chk("t4_valid_off", {31'd0, ifc.out_valid}, 32'd0);
        chk("t4_busy_off",  {31'd0, ifc.busy},      32'd0);
        send(16'h0005, 1'b1);
        wait_out(lat);
        chk("t4_new_sum",   {16'd0, ifc.out_sum},   32'h0005);
        chk("t4_new_count", {24'd0, ifc.out_count}, 32'd1);
        ifc.out_ready = 1'b1;
        @(negedge clk);

        // 5: reset during RESOLVE
        send(16'h00FF, 1'b0);
        send(16'h00FF, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("t5_rst_busy",  {31'd0, ifc.busy},      32'd0);
        chk("t5_rst_ready", {31'd0, ifc.in_ready},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_rel_ready", {31'd0, ifc.in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_no_result", {31'd0, ifc.out_valid}, 32'd0);
        end
        send(16'h0002, 1'b1);
        wait_out(lat);
        chk("t5_sum",   {16'd0, ifc.out_sum},   32'h0002);
        chk("t5_count", {24'd0, ifc.out_count}, 32'd1);
        @(negedge clk);

        // 6: 300 ones with random gaps, count saturates
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send(16'h0001, (i == 299));
        end
        wait_out(lat);
        chk("t6_latency", lat, 32'd5);
        chk("t6_sum",   {16'd0, ifc.out_sum},   32'h012C);
        chk("t6_count", {24'd0, ifc.out_count}, 32'd255);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csa_accum_ctrl.md
Name: csa_accum_ctrl

Overview:
- Multi-operand accumulator controller built on the team's 4-bit ripple-carry slice.
- Operands stream in over a valid/ready handshake and are compressed each cycle into carry-save form (sum vector S, carry vector C), so there is no carry propagation on the input path.
- On the last operand, the controller sequences one shared ripple_carry_4_bit instance across S and C, one nibble per cycle, to resolve the final sum.
- The result is held on an output valid/ready handshake until consumed.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of resolve cycles (local, derived).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  controller accepts an operand this cycle.
- in_data  input  WIDTH  operand value.
- in_last  input  1  qualifies in_data as the final operand of the set.
- out_valid  output  1  out_sum and out_count are valid.
- out_ready  input  1  consumer takes the result.
- out_sum  output  WIDTH  sum of all operands modulo 2^WIDTH.
- out_count  output  8  number of operands in the set; saturates at 255.
- busy  output  1  high in RESOLVE or DONE, or in ACCUM once at least one operand has been accepted.

Behaviour:
- Reset (async, rst=1) clears all state immediately:
  - State goes to ACCUM.
  - S, C, result register, nibble index, stored carry and count are cleared to 0.
  - out_valid=0, out_sum=0, out_count=0, busy=0.
  - in_ready=0 while rst is high.
- in_ready = (state==ACCUM) & ~rst. It is combinational from state; there is no dependence on in_valid.
- ACCUM state:
  - An operand is accepted when in_valid & in_ready.
  - On accept: S <= S^C^D.
  - On accept: C <= ((S&C)|(S&D)|(C&D)) << 1. The bit shifted out of the MSB is discarded (modulo arithmetic).
  - On accept: count <= min(count+1, 255).
  - If in_last is also high on accept: go to RESOLVE with nibble index k=0 and stored carry=0.
  - When in_valid=0, nothing changes.
- RESOLVE state (lasts NIB cycles):
  - Each cycle, the shared 4-bit slice adds S[4k+3:4k] + C[4k+3:4k] + carry.
  - The slice sum is written to result[4k+3:4k] and its cout to the carry register; k increments.
  - After k=NIB-1: go to DONE. The final cout is discarded.
  - in_ready=0 throughout; in_valid is ignored.
- DONE state:
  - out_valid=1; out_sum=result; out_count=count.
  - Outputs are held stable while out_ready=0.
  - On out_ready=1: out_valid drops the next cycle, S, C and count clear to 0, state returns to ACCUM, and in_ready=1 that cycle.
- Latency: if the last operand is accepted on edge T, out_valid rises on edge T+NIB+1. For WIDTH=16 that is 5 cycles.
- Throughput: one operand per cycle in ACCUM. There is no overlap between resolving one set and accumulating the next.
- Single-operand set (in_last on the first accept): result equals the operand and count=1.
- out_ready asserted outside DONE is ignored.
- Reset asserted mid-RESOLVE or mid-DONE aborts the set: no result is emitted and no state carries over.

Test Plan:
1. WIDTH=16; send 0x1234, 0x1111, 0x0001 (last on the third) back-to-back with out_ready=1 -> out_valid exactly 5 cycles after the last accept, out_sum=0x2346, out_count=3.
2. Send 0xFFFF, 0x0001(last) -> out_sum=0x0000, out_count=2; the carry must ripple through all 4 nibble cycles.
3. Send 0xABCD with in_last on the first beat -> out_sum=0xABCD, out_count=1.
4. Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 -> out_sum/out_count stable, in_ready=0, no operand consumed. Then pulse out_ready -> next cycle in_ready=1; a new set 0x0005(last) yields 0x0005, count 1 (no stale S/C).
5. Assert rst during RESOLVE of a 0x00FF+0x00FF set -> out_valid=0, busy=0, in_ready=0 while rst high and 1 after release. A following set 0x0002(last) yields 0x0002.
6. Send 300 operands of 0x0001 with last on the 300th, including random in_valid gaps -> out_sum=0x012C, out_count=255 (saturated).
